// File: rtl/fpu_pkg.sv
// Shared opcodes, arbiter state encoding and opcode-support helper for the FPU arbiter.
package fpu_pkg;

   localparam logic [3:0] FADD   = 4'd0;
   localparam logic [3:0] FSUB   = 4'd1;
   localparam logic [3:0] FMUL   = 4'd2;
   localparam logic [3:0] FINV   = 4'd3;
   localparam logic [3:0] FDIV   = 4'd4;
   localparam logic [3:0] FHALF  = 4'd5;
   localparam logic [3:0] FCMPLT = 4'd9;
   localparam logic [3:0] FCMPEQ = 4'd10;
   localparam logic [3:0] FABS   = 4'd11;
   localparam logic [3:0] FNEG   = 4'd12;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } arb_state_e;

   function automatic logic fpu_ctl_supported(input logic [3:0] ctl);
      logic ok;
      case (ctl)
         FADD, FSUB, FMUL, FINV, FDIV, FHALF, FCMPLT, FCMPEQ, FABS, FNEG: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping around.
module rr_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      // i runs 1..NREQ so the last-granted requester is checked last
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!found && req[(32'(ptr) + i) % NREQ]) begin
            found                          = 1'b1;
            grant[(32'(ptr) + i) % NREQ]   = 1'b1;
            idx                            = IW'((32'(ptr) + i) % NREQ);
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one FPU between NREQ requesters; holds operands for the whole
// operation, pulses en once, waits for ready (with timeout) and routes the result back.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [4*NREQ-1:0]  req_ctl,
   input  logic [32*NREQ-1:0] req_x1,
   input  logic [32*NREQ-1:0] req_x2,
   output logic [NREQ-1:0]    resp_valid,
   output logic [31:0]        resp_data,
   output logic               resp_err,
   output logic [3:0]         fpu_ctl,
   output logic [31:0]        fpu_x1,
   output logic [31:0]        fpu_x2,
   output logic               fpu_en,
   input  logic               fpu_ready,
   input  logic [31:0]        fpu_y,
   output logic               busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] gid_q, gid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    ctl_q, ctl_d;
   logic [31:0]   x1_q, x1_d;
   logic [31:0]   x2_q, x2_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   win_idx;
   logic [3:0]      win_ctl;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (win_idx)
   );

   assign win_ctl = req_ctl[int'(win_idx)*4 +: 4];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         rr_ptr_q <= IW'(NREQ - 1);
         gid_q    <= '0;
         cnt_q    <= '0;
         ctl_q    <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gid_q    <= gid_d;
         cnt_q    <= cnt_d;
         ctl_q    <= ctl_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gid_d     = gid_q;
      cnt_d     = cnt_q;
      ctl_d     = ctl_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      data_d    = data_q;
      err_d     = err_q;
      req_ready = '0;
      fpu_en    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               req_ready = grant;
               ctl_d     = win_ctl;
               x1_d      = req_x1[int'(win_idx)*32 +: 32];
               x2_d      = req_x2[int'(win_idx)*32 +: 32];
               gid_d     = win_idx;
               rr_ptr_d  = win_idx;
               if (fpu_ctl_supported(win_ctl)) begin
                  state_d = StIssue;
               end else begin
                  // Unsupported opcodes never reach the FPU
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StIssue: begin
            fpu_en  = 1'b1;
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (fpu_ready) begin
               data_d  = fpu_y;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      resp_valid = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         resp_valid[i] = (state_q == StResp) && (gid_q == IW'(i));
      end
   end

   assign resp_data = (state_q == StResp) ? data_q : 32'h0;
   assign resp_err  = (state_q == StResp) ? err_q : 1'b0;
   assign fpu_ctl   = ctl_q;
   assign fpu_x1    = x1_q;
   assign fpu_x2    = x2_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a stub FPU of per-opcode depth and a hang mode.
module tb_fpu_arbiter;
   import fpu_pkg::*;

   localparam int NREQ    = 3;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               rstn;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [4*NREQ-1:0]  req_ctl;
   logic [32*NREQ-1:0] req_x1;
   logic [32*NREQ-1:0] req_x2;
   logic [NREQ-1:0]    resp_valid;
   logic [31:0]        resp_data;
   logic               resp_err;
   logic [3:0]         fpu_ctl;
   logic [31:0]        fpu_x1;
   logic [31:0]        fpu_x2;
   logic               fpu_en;
   logic               fpu_ready;
   logic [31:0]        fpu_y;
   logic               busy;

   fpu_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ctl    (req_ctl),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .fpu_ctl    (fpu_ctl),
      .fpu_x1     (fpu_x1),
      .fpu_x2     (fpu_x2),
      .fpu_en     (fpu_en),
      .fpu_ready  (fpu_ready),
      .fpu_y      (fpu_y),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      int id;
      int cyc;
   } acc_t;

   exp_t exp_q[$];
   acc_t acc_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_acc = 0;
   int en_cnt = 0;
   int resp_count = 0;
   bit hang = 1'b0;
   bit pend = 1'b0;
   int scnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int nstage(input logic [3:0] ctl);
      case (ctl)
         FADD, FSUB: return 2;
         FMUL:       return 3;
         FINV:       return 4;
         FDIV:       return 9;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] fpu_model(input logic [3:0] ctl, input logic [31:0] a,
                                             input logic [31:0] b);
      case (ctl)
         FABS: return a & 32'h7FFF_FFFF;
         FNEG: return a ^ 32'h8000_0000;
         FADD: return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : 32'hDEAD_BEEF;
         FMUL: begin
            if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
            if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
            if (a == 32'h4080_0000 && b == 32'h3F00_0000) return 32'h4000_0000;
            return 32'hDEAD_BEEF;
         end
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Stub FPU: ready pulses NSTAGE+1 cycles after the en cycle; driven on negedges
   always @(negedge clk) begin
      fpu_ready = 1'b0;
      fpu_y     = 32'hA5A5_A5A5;
      if (!rstn) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            scnt--;
            if (scnt == 0) begin
               pend      = 1'b0;
               fpu_ready = 1'b1;
               fpu_y     = fpu_model(fpu_ctl, fpu_x1, fpu_x2);
            end
         end
         if (fpu_en && !hang) begin
            pend = 1'b1;
            scnt = nstage(fpu_ctl) + 1;
         end
      end
   end

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Monitor: logs acceptances, checks en timing and scores every response
   always @(negedge clk) begin
      if (rstn) begin
         acc_t a;
         exp_t e;
         check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         if (req_ready != '0) begin
            a.id  = onehot_idx(req_ready);
            a.cyc = cyc;
            acc_q.push_back(a);
            last_acc = cyc;
         end
         if (fpu_en) begin
            en_cnt++;
            check("en_after_accept", 32'(cyc), 32'(last_acc + 1));
         end
         if (resp_valid != '0) begin
            resp_count++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding", resp_valid);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("grant_id", 32'(a.id), 32'(e.id));
               check("resp_valid", 32'(resp_valid), 32'(1) << e.id);
               check("resp_data", resp_data, e.data);
               check("resp_err", 32'(resp_err), 32'(e.err));
               check("resp_latency", 32'(cyc - a.cyc), 32'(e.lat));
            end
         end else begin
            check("idle_resp_data", resp_data, 32'h0);
            check("idle_resp_err", 32'(resp_err), 32'h0);
         end
      end
   end

   task automatic push_exp(input int id, input logic [31:0] data, input logic err, input int lat);
      exp_t e;
      e.id = id; e.data = data; e.err = err; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int id, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b);
      req_ctl[id*4 +: 4]  = ctl;
      req_x1[id*32 +: 32] = a;
      req_x2[id*32 +: 32] = b;
      req_valid[id]       = 1'b1;
   endtask

   task automatic wait_accept(input int id);
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         done = req_ready[id];
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: requester %0d not granted, required grant", id);
      end
   endtask

   task automatic wait_resp(input int target);
      for (int n = 0; n < 200 && resp_count < target; n++) @(posedge clk);
      if (resp_count < target) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: %0d responses, required %0d", resp_count, target);
      end
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, "_resp_data"}, resp_data, 32'h0);
      check({tag, "_fpu_ctl"}, 32'(fpu_ctl), 32'h0);
      check({tag, "_fpu_x1"}, fpu_x1, 32'h0);
      check({tag, "_fpu_x2"}, fpu_x2, 32'h0);
      check({tag, "_fpu_en"}, 32'(fpu_en), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int e0;
      int t1;
      rstn      = 1'b0;
      req_valid = '0;
      req_ctl   = '0;
      req_x1    = '0;
      req_x2    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // fadd 1.0 + 2.0 from requester 0
      base = resp_count;
      e0   = en_cnt;
      push_exp(0, 32'h4040_0000, 1'b0, 5);
      set_req(0, FADD, 32'h3F80_0000, 32'h4000_0000);
      wait_accept(0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_resp(base + 1);
      check("fadd_en_pulses", 32'(en_cnt - e0), 32'd1);

      // fabs from requester 1, requester 2 queues behind it
      base = resp_count;
      push_exp(1, 32'h3F80_0000, 1'b0, 3);
      set_req(1, FABS, 32'hBF80_0000, 32'h0);
      wait_accept(1);
      t1 = cyc;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      push_exp(2, 32'hBF80_0000, 1'b0, 3);
      set_req(2, FNEG, 32'h3F80_0000, 32'h0);
      wait_accept(2);
      check("next_accept_gap", 32'(cyc - t1), 32'd4);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_resp(base + 2);

      // unsupported opcode never enables the FPU
      base = resp_count;
      e0   = en_cnt;
      push_exp(2, 32'h0, 1'b1, 1);
      set_req(2, 4'd7, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_accept(2);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_resp(base + 1);
      check("unsup_no_en", 32'(en_cnt - e0), 32'd0);

      // hung FPU times out, then a pending request is served
      hang = 1'b1;
      base = resp_count;
      push_exp(0, 32'h0, 1'b1, TIMEOUT + 2);
      push_exp(1, 32'hC000_0000, 1'b0, 3);
      set_req(0, FDIV, 32'h4040_0000, 32'h3F80_0000);
      wait_accept(0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      set_req(1, FNEG, 32'h4000_0000, 32'h0);
      wait_resp(base + 1);
      hang = 1'b0;
      wait_accept(1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_resp(base + 2);

      // reset in the middle of an fdiv wait abandons it
      base = resp_count;
      set_req(2, FDIV, 32'h4040_0000, 32'h3F80_0000);
      wait_accept(2);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy_before_reset", 32'(busy), 32'd1);
      rstn = 1'b0;
      #1;
      check_zero("mid_op_reset");
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      push_exp(0, 32'hBF80_0000, 1'b0, 3);
      push_exp(1, 32'h4000_0000, 1'b0, 3);
      push_exp(2, 32'h4040_0000, 1'b0, 3);
      set_req(0, FNEG, 32'h3F80_0000, 32'h0);
      set_req(1, FABS, 32'hC000_0000, 32'h0);
      set_req(2, FNEG, 32'hC040_0000, 32'h0);
      wait_resp(base + 3);
      req_valid = '0;

      // all three hold fmul from reset: grants 0,1,2,0,1
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      base = resp_count;
      push_exp(0, 32'h40C0_0000, 1'b0, 6);
      push_exp(1, 32'h4040_0000, 1'b0, 6);
      push_exp(2, 32'h4000_0000, 1'b0, 6);
      push_exp(0, 32'h40C0_0000, 1'b0, 6);
      push_exp(1, 32'h4040_0000, 1'b0, 6);
      set_req(0, FMUL, 32'h4000_0000, 32'h4040_0000);
      set_req(1, FMUL, 32'h3FC0_0000, 32'h4000_0000);
      set_req(2, FMUL, 32'h4080_0000, 32'h3F00_0000);
      wait_resp(base + 5);
      req_valid = '0;

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
